// File: rtl/fetch_controller_pkg.sv
// ============================================================================
// Module      : fetch_controller_pkg
// Description : Shared ISA constants and fetch state encoding for the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_controller_pkg;

    localparam int LEN_ADDRESS     = 32;
    localparam int LEN_INSTRUCTION = 32;

    localparam logic [LEN_INSTRUCTION-1:0] NOP_WORD  = 32'hE000_0000;
    localparam logic [LEN_INSTRUCTION-1:0] HALT_WORD = 32'hEAFF_FFFF;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_controller_if_id_register.sv
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register (instruction, pc, valid) with
//               flush > hold > load priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_register #(
    parameter int                         LEN_ADDRESS     = fetch_controller_pkg::LEN_ADDRESS,
    parameter int                         LEN_INSTRUCTION = fetch_controller_pkg::LEN_INSTRUCTION,
    parameter logic [LEN_INSTRUCTION-1:0] NOP_WORD        = fetch_controller_pkg::NOP_WORD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       hold,
    input  logic                       flush,
    input  logic [LEN_ADDRESS-1:0]     next_pc,
    input  logic [LEN_INSTRUCTION-1:0] next_instruction,
    output logic [LEN_ADDRESS-1:0]     pc,
    output logic [LEN_INSTRUCTION-1:0] instruction,
    output logic                       valid
);

    logic [LEN_ADDRESS-1:0]     r_pc;
    logic [LEN_INSTRUCTION-1:0] r_instruction;
    logic                       r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= '0;
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else if (flush) begin
            // A killed slot becomes a bubble so ID never sees stale data
            r_pc          <= '0;
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else if (!hold && load) begin
            r_pc          <= next_pc;
            r_instruction <= next_instruction;
            r_valid       <= 1'b1;
        end
    end

    assign pc          = r_pc;
    assign instruction = r_instruction;
    assign valid       = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : PC sequencing, start delay, stall/redirect and halt detection
//               for the instruction fetch stage. Optional macro FETCH_PERF_EN
//               adds saturating fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller #(
    parameter int                      LEN_ADDRESS = fetch_controller_pkg::LEN_ADDRESS,
    parameter logic [LEN_ADDRESS-1:0]  RESET_PC    = '0,
    parameter int                      START_DELAY = 4,
    parameter logic [31:0]             NOP_WORD    = fetch_controller_pkg::NOP_WORD,
    parameter logic [31:0]             HALT_WORD   = fetch_controller_pkg::HALT_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [LEN_ADDRESS-1:0] branch_address,
    output logic [LEN_ADDRESS-1:0] mem_address,
    input  logic [31:0]            mem_instruction,
    output logic [LEN_ADDRESS-1:0] if_pc,
    output logic [31:0]            if_instruction,
    output logic                   if_valid,
    output logic                   flush,
    output logic                   halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count
`endif
);

    import fetch_controller_pkg::*;

    localparam logic [3:0] c_delay_last = 4'(START_DELAY - 1);

    fetch_state_e           r_state;
    logic [LEN_ADDRESS-1:0] r_pc;
    logic [LEN_ADDRESS-1:0] r_halt_pc;
    logic [3:0]             r_delay_cnt;
    logic                   r_halted;

    logic [LEN_ADDRESS-1:0] w_branch_target;
    logic [LEN_ADDRESS-1:0] w_pc_plus4;
    logic                   w_is_halt_word;
    logic                   w_ifid_clear;
    logic                   w_ifid_hold;
    logic                   w_ifid_load;
    logic [1:0]             w_unused_branch_bits;

    // Word alignment is enforced by truncation; low address bits never fault
    assign w_branch_target      = {branch_address[LEN_ADDRESS-1:2], 2'b00};
    assign w_unused_branch_bits = branch_address[1:0];
    assign w_pc_plus4           = r_pc + LEN_ADDRESS'(4);
    assign w_is_halt_word       = (mem_instruction == HALT_WORD);
    assign mem_address          = {r_pc[LEN_ADDRESS-1:2], 2'b00};

    assign flush  = branch_taken && ((r_state == ST_RUN) || (r_state == ST_HALT));
    assign halted = r_halted;

    assign w_ifid_clear = (r_state == ST_WAIT) || (r_state == ST_HALT) ||
                          ((r_state == ST_RUN) && branch_taken);
    assign w_ifid_hold  = (r_state == ST_RUN) && !branch_taken && freeze;
    assign w_ifid_load  = (r_state == ST_RUN) && !branch_taken && !freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_WAIT;
            r_pc        <= RESET_PC;
            r_halt_pc   <= '0;
            r_delay_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_delay_cnt == c_delay_last) begin
                        r_state     <= ST_RUN;
                        r_delay_cnt <= '0;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        r_pc <= w_branch_target;
                    end else if (!freeze) begin
                        // The halt word is still latched into IF/ID; only the pc stops
                        if (w_is_halt_word) begin
                            r_halt_pc <= mem_address;
                            r_state   <= ST_HALT;
                            r_halted  <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                ST_HALT: begin
                    // A redirect elsewhere means the halt word was on a wrong path
                    if (branch_taken && (w_branch_target != r_halt_pc)) begin
                        r_pc     <= w_branch_target;
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_WAIT;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    if_id_register #(
        .LEN_ADDRESS     (LEN_ADDRESS),
        .LEN_INSTRUCTION (32),
        .NOP_WORD        (NOP_WORD)
    ) u_if_id (
        .clk              (clk),
        .rst              (rst),
        .load             (w_ifid_load),
        .hold             (w_ifid_hold),
        .flush            (w_ifid_clear),
        .next_pc          (w_pc_plus4),
        .next_instruction (mem_instruction),
        .pc               (if_pc),
        .instruction      (if_instruction),
        .valid            (if_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_ifid_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_ifid_hold && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module      : tb_fetch_controller
// Description : Table-driven scoreboard bench for fetch_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_controller;

    localparam logic [31:0] NOP_W  = 32'hE000_0000;
    localparam logic [31:0] HALT_W = 32'hEAFF_FFFF;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] mem_address;
    logic [31:0] mem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        flush;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_controller dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .if_valid        (if_valid),
        .flush           (flush),
        .halted          (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: sequential pattern words, halt word planted at 0xBC
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_00BC) return HALT_W;
        return {8'hA5, a[25:2]};
    endfunction

    always_comb mem_instruction = mem_word(mem_address);

    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] ba;
        logic        exp_flush;
        logic [31:0] exp_mem;
        logic [31:0] exp_ifpc;
        logic        exp_valid;
        logic        exp_halted;
        int          f;
        int          s;
    } vec_t;

    vec_t vecs[40];
    int   nv;
    vec_t exp_q[$];

    int checks;
    int errors;
    int fetch_exp;
    int stall_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic frz, input logic br, input logic [31:0] ba,
                       input logic fl, input logic [31:0] ma, input logic [31:0] ipc,
                       input logic vl, input logic hl, input int f, input int s);
        vecs[nv] = '{frz, br, ba, fl, ma, ipc, vl, hl, f, s};
        nv++;
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t        e;
        logic [31:0] exp_instr;
        @(negedge clk);
        freeze         = v.frz;
        branch_taken   = v.br;
        branch_address = v.ba;
        #1;
        chk($sformatf("row%0d flush", idx), {31'd0, flush}, {31'd0, v.exp_flush});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        exp_instr = e.exp_valid ? mem_word(e.exp_ifpc - 32'd4) : NOP_W;
        chk($sformatf("row%0d mem_address", idx), mem_address, e.exp_mem);
        chk($sformatf("row%0d if_pc", idx), if_pc, e.exp_ifpc);
        chk($sformatf("row%0d if_instruction", idx), if_instruction, exp_instr);
        chk($sformatf("row%0d if_valid", idx), {31'd0, if_valid}, {31'd0, e.exp_valid});
        chk($sformatf("row%0d halted", idx), {31'd0, halted}, {31'd0, e.exp_halted});
        fetch_exp += e.f;
        stall_exp += e.s;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " mem_address"}, mem_address, 32'h0);
        chk({tag, " if_pc"}, if_pc, 32'h0);
        chk({tag, " if_instruction"}, if_instruction, NOP_W);
        chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, " halted"}, {31'd0, halted}, 32'd0);
        chk({tag, " flush"}, {31'd0, flush}, 32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, " fetch_count"}, fetch_count, 32'd0);
        chk({tag, " stall_count"}, stall_count, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; nv = 0; fetch_exp = 0; stall_exp = 0;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;

        //   frz br  addr           fl  mem            if_pc          v  h  f  s
        add(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 0, 0); // WAIT
        add(1, 1, 32'h80,        0, 32'h0,         32'h0,        0, 0, 0, 0); // ignored in WAIT
        add(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,         0, 32'h0,         32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,         0, 32'h4,         32'h4,        1, 0, 1, 0); // first fetch
        add(0, 0, 32'h0,         0, 32'h8,         32'h8,        1, 0, 1, 0);
        add(0, 0, 32'h0,         0, 32'hC,         32'hC,        1, 0, 1, 0);
        add(0, 0, 32'h0,         0, 32'h10,        32'h10,       1, 0, 1, 0);
        add(1, 0, 32'h0,         0, 32'h10,        32'h10,       1, 0, 0, 1); // freeze x3
        add(1, 0, 32'h0,         0, 32'h10,        32'h10,       1, 0, 0, 1);
        add(1, 0, 32'h0,         0, 32'h10,        32'h10,       1, 0, 0, 1);
        add(0, 0, 32'h0,         0, 32'h14,        32'h14,       1, 0, 1, 0);
        add(1, 1, 32'h43,        1, 32'h40,        32'h0,        0, 0, 0, 0); // branch+freeze
        add(0, 0, 32'h0,         0, 32'h44,        32'h44,       1, 0, 1, 0);
        add(0, 1, 32'hB5,        1, 32'hB4,        32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,         0, 32'hB8,        32'hB8,       1, 0, 1, 0);
        add(0, 0, 32'h0,         0, 32'hBC,        32'hBC,       1, 0, 1, 0);
        add(0, 0, 32'h0,         0, 32'hBC,        32'hC0,       1, 1, 1, 0); // halt word latched
        add(0, 0, 32'h0,         0, 32'hBC,        32'h0,        0, 1, 0, 0);
        add(1, 0, 32'h0,         0, 32'hBC,        32'h0,        0, 1, 0, 0); // freeze in HALT
        add(0, 1, 32'hBC,        1, 32'hBC,        32'h0,        0, 1, 0, 0); // self-branch
        add(0, 1, 32'hBE,        1, 32'hBC,        32'h0,        0, 1, 0, 0); // unaligned self
        add(0, 1, 32'h68,        1, 32'h68,        32'h0,        0, 0, 0, 0); // speculative halt
        add(0, 0, 32'h0,         0, 32'h6C,        32'h6C,       1, 0, 1, 0);
        add(0, 1, 32'hBC,        1, 32'hBC,        32'h0,        0, 0, 0, 0);
        add(1, 0, 32'h0,         0, 32'hBC,        32'h0,        0, 0, 0, 1); // frozen halt word
        add(0, 1, 32'hBC,        1, 32'hBC,        32'h0,        0, 0, 0, 0); // flushed halt word
        add(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,         0, 32'h0,         32'h0,        1, 0, 1, 0); // wrap
        add(0, 0, 32'h0,         0, 32'h4,         32'h4,        1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < nv; i++) step(vecs[i], i);

`ifdef FETCH_PERF_EN
        chk("perf fetch_count", fetch_count, 32'(fetch_exp));
        chk("perf stall_count", stall_count, 32'(stall_exp));
`endif

        // Asynchronous reset between edges must clear outputs without a clock
        #2 rst = 1'b0;
        #1;
        chk_reset_state("async_reset");
        freeze = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("reset_held");
        #1 rst = 1'b1;
        fetch_exp = 0;
        stall_exp = 0;
        for (int i = 0; i < 8; i++) step(vecs[i], 100 + i);

`ifdef FETCH_PERF_EN
        chk("perf2 fetch_count", fetch_count, 32'(fetch_exp));
        chk("perf2 stall_count", stall_count, 32'(stall_exp));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction memory for the 5-stage pipelined core.
- Owns the PC and drives the byte address into instruction memory, which returns a 32-bit word combinationally.
- Registers the fetched word into the IF/ID pipeline register.
- Handles freeze (hazard stall), branch redirect with flush, a post-reset start delay, and halt detection on the branch-to-self word that terminates test programs.

Parameters:
- LEN_ADDRESS, 32, PC and memory address width in bits.
- RESET_PC, 0, PC value loaded at reset.
- START_DELAY, 4, cycles spent in WAIT after reset before the first fetch (range 1..15).
- NOP_WORD, 32'hE000_0000, bubble instruction.
- HALT_WORD, 32'hEAFF_FFFF, unconditional branch-to-self that triggers halt.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall from the hazard unit.
- branch_taken  in  1  branch resolved taken in EXE.
- branch_address  in  LEN_ADDRESS  branch target.
- mem_address  out  LEN_ADDRESS  address to instruction memory.
- mem_instruction  in  32  word returned by instruction memory.
- if_pc  out  LEN_ADDRESS  fetched address + 4.
- if_instruction  out  32  IF/ID instruction.
- if_valid  out  1  IF/ID slot holds a real instruction.
- flush  out  1  combinational, equals branch_taken while in RUN or HALT; tells ID to kill its slot.
- halted  out  1  high while in HALT.

Behaviour:
- Reset values (async, rst=0):
  - pc=RESET_PC, state=WAIT, delay counter=0.
  - if_instruction=NOP_WORD, if_pc=0, if_valid=0, halted=0.
  - Asserting reset mid-operation aborts everything immediately.
- mem_address = {pc[LEN_ADDRESS-1:2],2'b00} at all times. Fetch latency is zero cycles to memory and one cycle to IF/ID.
- WAIT state:
  - Counter increments each cycle and pc holds.
  - IF/ID holds NOP with valid=0.
  - freeze and branch_taken are ignored; flush=0.
  - When counter reaches START_DELAY-1, go to RUN.
- RUN state, priority branch_taken > freeze > normal:
  - branch_taken:
    - pc <= {branch_address[LEN_ADDRESS-1:2],2'b00}.
    - IF/ID <= NOP_WORD, valid=0, if_pc=0.
    - Applies even when freeze=1.
  - freeze (no branch): pc and IF/ID hold unchanged.
  - Normal:
    - if_instruction <= mem_instruction, if_pc <= pc+4, valid=1.
    - pc <= pc+4, modulo 2^LEN_ADDRESS, so 0xFFFF_FFFC wraps to 0.
  - Halt detect (normal path only, mem_instruction==HALT_WORD):
    - Word is latched normally with valid=1.
    - halt_pc <= pc; pc holds (not incremented); go to HALT.
    - A frozen or flushed HALT_WORD does not halt.
- HALT state:
  - halted=1, pc holds; IF/ID <= NOP, valid=0 every cycle.
  - branch_taken with target==halt_pc: the halt word executing. Stay in HALT; no pc change.
  - branch_taken with target!=halt_pc: an older branch redirects away, so the halt word was speculative. pc <= target, go to RUN, halted=0.
  - freeze is ignored.
- Unaligned branch_address: low 2 bits are dropped, never an error.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined, add two outputs:
  - fetch_count, 32 bits: increments on each normal-path latch with valid=1.
  - stall_count, 32 bits: increments on each RUN cycle with freeze=1 and branch_taken=0.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro: no ports and no logic for the counters.

Decomposition:
- Shared ISA package/header holds:
  - LEN_ADDRESS and LEN_INSTRUCTION.
  - NOP_WORD and HALT_WORD constants.
  - State encoding WAIT=2'd0, RUN=2'd1, HALT=2'd2.
- Natural sub-module: if_id_register, holding the instruction, pc and valid fields, with load, hold and flush controls and async active-low reset.
- PC/state logic stays in fetch_controller.

Test Plan:
- Reset release with START_DELAY=4 and memory preloaded with sequential words:
  - mem_address stays 0 and if_valid=0 for 4 cycles.
  - Then if_pc=4, 8, 12 on consecutive cycles, and if_instruction matches memory words 0, 1, 2.
- freeze=1 for 3 cycles at pc=0x10: pc, if_pc=0x10 and if_instruction are held; resume gives if_pc=0x14.
- Branch with freeze: branch_taken=1, branch_address=0x43, freeze=1 in the same cycle.
  - flush=1 that cycle.
  - Next cycle: mem_address=0x40, if_instruction=NOP_WORD, if_valid=0.
  - Following cycle: if_pc=0x44.
- HALT_WORD at 0xBC, then a self-branch:
  - The word is latched with valid=1 and if_pc=0xC0; halted=1; mem_address stays 0xBC.
  - A later branch_taken to 0xBC keeps halted=1.
- Speculative halt: in HALT with halt_pc=0xBC, branch_taken to 0x68 → halted=0, mem_address=0x68, and normal fetch resumes.
- Wrap and reset:
  - pc=0xFFFF_FFFC normal fetch → next mem_address=0.
  - rst=0 pulsed mid-RUN asynchronously (between clock edges) → outputs return to reset values immediately, and the bench re-enters WAIT.
  - With FETCH_PERF_EN: counters clear on that reset, and stall_count equals the number of freeze cycles.
